// File: rtl/i2s_transmitter.sv
// I2S transmitter: derives BCLK/LRCLK from the system clock with counters,
// latches one mono sample per frame and sends it in both the left and right
// slots, MSB first, one BCLK after each LRCLK edge.
module i2s_transmitter #(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int SLOT_WIDTH       = 32,
    parameter int BCLK_HALF_PERIOD = 8,
    parameter bit UNSIGNED_IN      = 1'b1
) (
    input  logic                    clock_50_000_000,
    input  logic                    reset_l,
    input  logic [SAMPLE_WIDTH-1:0] audio,
    input  logic                    mute,
    output logic                    sample_strobe,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_data
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_HALF_PERIOD > 1) ? $clog2(BCLK_HALF_PERIOD) : 1;

    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(BCLK_HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]        BIT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]        L_LAST   = CNT_W'(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0]        R_START  = CNT_W'(SLOT_WIDTH);
    localparam logic [CNT_W-1:0]        R_LAST   = CNT_W'(SLOT_WIDTH + SAMPLE_WIDTH);
    localparam logic [SAMPLE_WIDTH-1:0] MSB_MASK = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);

    // A sample must leave at least the one-BCLK delay slot free, and the
    // divider needs two clocks per half period to produce a 50% duty BCLK.
    generate
        if (SAMPLE_WIDTH > SLOT_WIDTH - 1 || BCLK_HALF_PERIOD < 2) begin : g_bad_params
            $error("i2s_transmitter: need SAMPLE_WIDTH <= SLOT_WIDTH-1 and BCLK_HALF_PERIOD >= 2");
        end
    endgenerate

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic                    bclk_q, bclk_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    lrclk_q, lrclk_d;
    logic                    data_q, data_d;
    logic                    strobe_q, strobe_d;
    logic [SAMPLE_WIDTH-1:0] held_q, held_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;

    logic                    bclk_fall;
    logic [SAMPLE_WIDTH-1:0] audio_tc;

    // Divider, bit counter, sample latch and serialiser; everything except
    // BCLK itself moves only on the cycle a BCLK fall is registered.
    always_comb begin
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        data_d    = data_q;
        strobe_d  = 1'b0;
        held_d    = held_q;
        shift_d   = shift_q;
        bclk_fall = 1'b0;
        audio_tc  = audio;

        if (UNSIGNED_IN) begin
            audio_tc = audio ^ MSB_MASK;
        end

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
            bclk_fall = bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (bclk_fall) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
            lrclk_d   = (bit_cnt_d >= R_START);
            data_d    = 1'b0;
            if (bit_cnt_d == '0) begin
                // Frame start: padding bit goes out while the new sample is captured.
                held_d   = mute ? '0 : audio_tc;
                shift_d  = held_d;
                strobe_d = 1'b1;
            end else if (bit_cnt_d == R_START) begin
                // Right slot replays the same held sample.
                shift_d = held_q;
            end else if ((bit_cnt_d <= L_LAST) ||
                         ((bit_cnt_d > R_START) && (bit_cnt_d <= R_LAST))) begin
                data_d  = shift_q[SAMPLE_WIDTH-1];
                shift_d = shift_q << 1;
            end
        end
    end

    // State registers with synchronous active-low reset; reset aborts any frame in flight.
    always_ff @(posedge clock_50_000_000) begin
        if (!reset_l) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= BIT_LAST;
            lrclk_q   <= 1'b1;
            data_q    <= 1'b0;
            strobe_q  <= 1'b0;
            held_q    <= '0;
            shift_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            lrclk_q   <= lrclk_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            held_q    <= held_d;
            shift_q   <= shift_d;
        end
    end

    assign sample_strobe = strobe_q;
    assign i2s_bclk      = bclk_q;
    assign i2s_lrclk     = lrclk_q;
    assign i2s_data      = data_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter at default parameters: directed frames plus
// random frames, with a deserialising monitor checking words from a queue.
module tb_i2s_transmitter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_l = 1'b0;
    logic [W-1:0] audio = 16'hC000;
    logic         mute = 1'b0;
    logic         sample_strobe;
    logic         i2s_bclk;
    logic         i2s_lrclk;
    logic         i2s_data;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int words_done = 0;
    int pad_bad = 0;
    int edge_bad = 0;
    bit mon_en = 1'b1;

    i2s_transmitter dut (
        .clock_50_000_000(clk),
        .reset_l        (reset_l),
        .audio          (audio),
        .mute           (mute),
        .sample_strobe  (sample_strobe),
        .i2s_bclk       (i2s_bclk),
        .i2s_lrclk      (i2s_lrclk),
        .i2s_data       (i2s_data)
    );

    always #10 clk = ~clk;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push2(input logic [W-1:0] a, input logic m);
        logic [W-1:0] e;
        e = m ? 16'h0000 : (a ^ 16'h8000);
        exp_q.push_back(e);
        exp_q.push_back(e);
    endtask

    // Counts system clocks until sample_strobe is seen; bounded.
    task automatic wait_strobe(output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < 1200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (sample_strobe) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: no sample_strobe within %0d clocks", n);
        end
    endtask

    // Monitor: deserialise on BCLK rises and compare each completed word.
    int          idx = 0;
    bit          synced = 1'b0;
    logic        prev_lr = 1'b1;
    logic        bclk_prev = 1'b0;
    logic        data_prev = 1'b0;
    logic        lr_prev = 1'b1;
    logic [W-1:0] word = '0;
    logic [W-1:0] exp_w;
    always @(negedge clk) begin
        if (!reset_l) begin
            synced    = 1'b0;
            prev_lr   = 1'b1;
            bclk_prev = 1'b0;
            data_prev = 1'b0;
            lr_prev   = 1'b1;
            idx       = 0;
        end else begin
            if (i2s_bclk && !bclk_prev) begin
                if (i2s_data != data_prev || i2s_lrclk != lr_prev) edge_bad++;
                if (i2s_lrclk != prev_lr) begin
                    synced = 1'b1;
                    idx    = 0;
                end else begin
                    idx++;
                end
                prev_lr = i2s_lrclk;
                if (synced && mon_en) begin
                    if (idx >= 1 && idx <= W) begin
                        word = {word[W-2:0], i2s_data};
                        if (idx == W) begin
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL word_unexpected: got %h with empty queue", word);
                            end else begin
                                exp_w = exp_q.pop_front();
                                if (word != exp_w) begin
                                    errors++;
                                    $display("FAIL word_%0s: got %h expected %h",
                                             i2s_lrclk ? "right" : "left", word, exp_w);
                                end
                            end
                            words_done++;
                        end
                    end else if (i2s_data) begin
                        pad_bad++;
                    end
                end
            end
            bclk_prev = i2s_bclk;
            data_prev = i2s_data;
            lr_prev   = i2s_lrclk;
        end
    end

    // Timing of the first 2048 clocks after the first reset release.
    initial begin
        int strobe_cnt, strobe_first, strobe_second, bclk_bad, lrclk_bad;
        logic exp_lr;
        strobe_cnt = 0; strobe_first = -1; strobe_second = -1;
        bclk_bad = 0; lrclk_bad = 0;
        @(posedge reset_l);
        for (int n = 1; n <= 2048; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (i2s_bclk != logic'((n / 8) % 2)) bclk_bad++;
            if (n < 16) exp_lr = 1'b1;
            else exp_lr = logic'(((n - 16) / 512) % 2);
            if (i2s_lrclk != exp_lr) lrclk_bad++;
            if (sample_strobe) begin
                strobe_cnt++;
                if (strobe_cnt == 1) strobe_first = n;
                if (strobe_cnt == 2) strobe_second = n;
            end
        end
        check_int("bclk_pattern_bad_cycles", bclk_bad, 0);
        check_int("lrclk_pattern_bad_cycles", lrclk_bad, 0);
        check_int("first_strobe_clock", strobe_first, 16);
        check_int("second_strobe_clock", strobe_second, 1040);
        check_int("strobe_count_2048", strobe_cnt, 2);
    end

    // Stimulus
    initial begin
        int n;
        logic [W-1:0] a;
        logic m;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("reset_bclk", int'(i2s_bclk), 0);
        check_int("reset_lrclk", int'(i2s_lrclk), 1);
        check_int("reset_data", int'(i2s_data), 0);
        check_int("reset_strobe", int'(sample_strobe), 0);
        push2(16'hC000, 1'b0);                  // held 16'h4000
        reset_l = 1'b1;

        wait_strobe(n);
        repeat (4) @(posedge clk);
        #1 audio = 16'h8000;                    // held 0
        push2(16'h8000, 1'b0);
        wait_strobe(n);
        repeat (4) @(posedge clk);
        #1 audio = 16'hFFFF; mute = 1'b1;       // muted -> 0
        push2(16'hFFFF, 1'b1);
        wait_strobe(n);
        repeat (4) @(posedge clk);
        #1 audio = 16'h1234; mute = 1'b0;       // held 16'h9234
        push2(16'h1234, 1'b0);
        wait_strobe(n);
        repeat (284) @(posedge clk);            // clock 300 of the frame
        #1 audio = 16'hABCD;                    // held 16'h2BCD next frame
        push2(16'hABCD, 1'b0);
        wait_strobe(n);

        // One-cycle reset at clock 700 of the frame, mid right slot.
        repeat (684) @(posedge clk);
        #1 reset_l = 1'b0;
        exp_q.delete();
        exp_q.push_back(16'h2BCD);              // left word of this frame already done
        exp_q.delete();
        audio = 16'h5A5A;                       // held 16'hDA5A
        push2(16'h5A5A, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_int("midreset_bclk", int'(i2s_bclk), 0);
        check_int("midreset_lrclk", int'(i2s_lrclk), 1);
        check_int("midreset_data", int'(i2s_data), 0);
        check_int("midreset_strobe", int'(sample_strobe), 0);
        reset_l = 1'b1;
        wait_strobe(n);
        check_int("strobe_after_reset_clock", n, 16);

        for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(1, 900)) @(posedge clk);
            a = W'($urandom);
            m = ($urandom_range(0, 7) == 0);
            #1 audio = a; mute = m;
            push2(a, m);
            wait_strobe(n);
        end
        repeat (800) @(posedge clk);
        mon_en = 1'b0;

        check_int("queue_left_over", exp_q.size(), 0);
        check_int("words_checked", words_done, 111);
        check_int("padding_ones", pad_bad, 0);
        check_int("changes_on_bclk_rise", edge_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Downstream stage of the synth pipeline: consumes the per-clock mono `audio` word and serialises it to an external I2S DAC.
- Generates BCLK, LRCLK and SDATA from the 50 MHz system clock with counters; no PLL.
- Latches one sample per frame and duplicates it to the left and right slots.
- Pulses `sample_strobe` at each latch so upstream blocks can align to the frame.

Parameters:
SAMPLE_WIDTH, 16, width of the `audio` input and of each serialised sample; must be <= SLOT_WIDTH-1.
SLOT_WIDTH, 32, BCLK periods per channel slot; a frame is 2*SLOT_WIDTH BCLKs.
BCLK_HALF_PERIOD, 8, system clocks per BCLK half period (default 3.125 MHz BCLK, 48.828 kHz frame).
UNSIGNED_IN, 1, 1: `audio` is offset-binary, so invert the MSB to make two's complement; 0: pass through unchanged.

Ports:
clock_50_000_000  input  1  system clock.
reset_l  input  1  synchronous active-low reset.
audio  input  SAMPLE_WIDTH  sample from the pipeline; sampled only at the latch cycle.
mute  input  1  when high at the latch cycle, the latched sample is 0 (two's complement).
sample_strobe  output  1  one-cycle pulse on the cycle the sample is latched.
i2s_bclk  output  1  bit clock.
i2s_lrclk  output  1  word select; 0 = left, 1 = right.
i2s_data  output  1  serial data, MSB first, standard I2S one-BCLK delay.

Behaviour:
- Reset (reset_l low at a rising edge):
  - i2s_bclk=0, i2s_lrclk=1, i2s_data=0, sample_strobe=0.
  - div_cnt=0; bit_cnt=2*SLOT_WIDTH-1; shift register and held sample cleared.
  - Reset mid-frame aborts the frame immediately with no partial-word flush.
- Divider:
  - div_cnt counts 0..BCLK_HALF_PERIOD-1 and wraps.
  - On the wrap cycle i2s_bclk toggles, so it is a registered output with 50% duty.
  - After reset release, the first BCLK rise occurs at the H-th clock and the first fall at the 2H-th clock (H = BCLK_HALF_PERIOD).
- Falling edge (the cycle the 1->0 toggle is registered):
  - bit_cnt increments modulo 2*SLOT_WIDTH.
  - i2s_lrclk and i2s_data update in the same cycle; nothing changes on rising edges.
- Latch, when the new bit_cnt == 0:
  - held = (UNSIGNED_IN ? audio with MSB inverted : audio), or 0 if mute.
  - sample_strobe=1 for exactly this one system clock.
  - Both slots of the frame use this held value.
- Output mapping by new bit_cnt value b (S = SLOT_WIDTH, W = SAMPLE_WIDTH):
  - b = 0: lrclk=0, data=0 (padding tail of the right slot).
  - b = 1..W: lrclk=0, data = held[W-b] (MSB at b=1).
  - b = W+1..S-1: lrclk=0, data=0.
  - b = S: lrclk=1, data=0.
  - b = S+1..S+W: lrclk=1, data = held[S+W-b].
  - b = S+W+1..2S-1: lrclk=1, data=0.
- The DAC samples on BCLK rising edges; data is stable for a full BCLK period around each rise.
- Frame period = 2*BCLK_HALF_PERIOD*2*SLOT_WIDTH system clocks (1024 at defaults); sample_strobe period is identical.
- Changes to audio or mute between latches have no effect on the frame in flight.
- Elaboration error if SAMPLE_WIDTH > SLOT_WIDTH-1 or BCLK_HALF_PERIOD < 2.

Test Plan:
- Reset, then run 2048 cycles at defaults -> i2s_bclk toggles every 8 clocks; first fall at clock 16; first sample_strobe at clock 16; next strobe at clock 1040; i2s_lrclk low for 512 clocks then high for 512.
- audio=16'hC000, UNSIGNED_IN=1, mute=0 -> held=16'h4000; left slot bits b=1..16 read 0100_0000_0000_0000; b=17..31 zero; right slot identical.
- audio=16'h8000, UNSIGNED_IN=1 -> held=0; i2s_data stays 0 for the whole frame. Same frame with audio=16'hFFFF and mute=1 -> all zeros.
- Change audio from 16'h1234 to 16'hABCD at clock 300 (mid-frame) -> current frame still serialises the held value derived from 16'h1234 in both slots; the new value appears only after the next strobe.
- Assert reset_l low for one cycle at clock 700, mid right slot -> next cycle all outputs at reset values; the first strobe after release occurs 16 clocks later.
- Scoreboard: random audio for 50 frames, with a model deserialising on BCLK rises using the one-BCLK delay -> every left and right word equals the expected held value; no data transitions on rising BCLK edges.
